ifft_frame_ctrl: RTL and testbench
==================================

Name: ifft_frame_ctrl

Overview:
- Sequencer in front of the ifft core.
- On each start request it issues one 24-bit config word on the core's S_AXIS_CONFIG channel, then streams an upstream subcarrier sample flow into S_AXIS_DATA.
- Frames the data stream into N = 2^nfft_log2 samples per frame and generates tlast itself.
- Counts frames, watches the core's tlast event flags and reports completion and errors to the OFDM top level.

Parameters:
- DATA_W, 32, sample width (bits [31:16] imaginary, [15:0] real), passed through unchanged
- MAX_LOG2, 6, largest accepted nfft_log2 (64-point)
- FRAMES_W, 8, width of the frames-per-burst request and frame counter

Ports:
- aclk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request; honoured only in IDLE
- nfft_log2  in  5  transform size, valid range 3..MAX_LOG2
- cp_len  in  7  cyclic prefix length for the config word
- fwd_inv  in  1  1 = forward, 0 = inverse
- frames  in  FRAMES_W  frames to stream this burst, must be ≥1
- s_tdata  in  DATA_W  upstream sample
- s_tvalid  in  1  upstream valid
- s_tready  out  1  upstream ready
- cfg_tdata  out  24  to S_AXIS_CONFIG_tdata
- cfg_tvalid  out  1  to S_AXIS_CONFIG_tvalid
- cfg_tready  in  1  from S_AXIS_CONFIG_tready
- dat_tdata  out  DATA_W  to S_AXIS_DATA_tdata
- dat_tvalid  out  1  to S_AXIS_DATA_tvalid
- dat_tready  in  1  from S_AXIS_DATA_tready
- dat_tlast  out  1  to S_AXIS_DATA_tlast
- ev_tlast_missing  in  1  core event_tlast_missing
- ev_tlast_unexpected  in  1  core event_tlast_unexpected
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse when the burst completes
- err_cfg  out  1  one-cycle pulse when a start is rejected
- err_tlast  out  1  sticky core tlast error
- frame_cnt  out  FRAMES_W  frames completed in the current or last burst

Behaviour:
- Reset values: all outputs 0; state IDLE; sample counter and frame_cnt 0; latched config 0.
- Config word format: {7'b0, fwd_inv, 1'b0, cp_len[6:0], 3'b0, nfft_log2[4:0]}.
- IDLE, start=1, nfft_log2 in 3..MAX_LOG2, frames≠0:
  - latch nfft_log2, cp_len, fwd_inv, frames
  - clear frame_cnt and err_tlast
  - next state CFG
- IDLE, start=1, any field invalid: pulse err_cfg next cycle, stay IDLE.
- start outside IDLE is ignored, with no error.
- CFG:
  - cfg_tvalid=1, cfg_tdata built from latched fields
  - cfg_tdata is held stable until cfg_tready
  - on cfg_tvalid&cfg_tready, go to DATA next cycle
- DATA, combinational pass-through:
  - dat_tdata = s_tdata
  - dat_tvalid = s_tvalid
  - s_tready = dat_tready
  - zero latency, no buffering
- DATA counters:
  - sample counter increments on dat_tvalid&dat_tready
  - dat_tlast = (count == N-1); it depends only on the count, not on valid
- Last handshake of a frame (tlast):
  - counter wraps to 0
  - frame_cnt increments
  - if frame_cnt+1 == frames, go to DONE; else stay in DATA
- DONE: s_tready=0, dat_tvalid=0; pulse done for one cycle; return to IDLE next cycle.
- Outside DATA: s_tready=0, dat_tvalid=0, dat_tlast=0.
- err_tlast:
  - set when ev_tlast_missing or ev_tlast_unexpected is high in any state
  - sticky until the next accepted start
  - does not halt sequencing
- Reset mid-burst: immediate return to IDLE; valid outputs drop in the same cycle rst is sampled. A partially sent frame is abandoned; the core must be reset alongside.
- Start and config latch in the same cycle: config values on the start cycle are used.

Optional Feature:
- Macro IFFT_FRAME_CTRL_CFG_CACHE_EN.
- Defined:
  - the block keeps the last config word accepted by the core (valid flag cleared by rst)
  - an accepted start whose word equals the cached one goes IDLE→DATA directly, with no config transfer
- Undefined: every accepted start passes through CFG.

Test Plan:
- Reset, then start with nfft_log2=3, cp_len=64, fwd_inv=0, frames=1, upstream always valid, core always ready:
  - cfg_tdata=24'h004003 for exactly one handshake
  - 8 data beats, tlast on beat 8 only
  - done pulses, frame_cnt=1
- frames=3, nfft_log2=4, dat_tready toggling every other cycle:
  - 48 beats, tlast on beats 16/32/48
  - tdata order preserved, no beats lost or duplicated
- cfg_tready held low for 5 cycles: cfg_tvalid and cfg_tdata stay stable, no data accepted until the handshake.
- start with nfft_log2=7, or with frames=0: err_cfg pulse, busy stays 0, no config issued.
- ev_tlast_unexpected pulsed during DATA: err_tlast=1 and stays; burst completes normally; cleared on the next start.
- rst asserted on beat 5 of an 8-beat frame: next cycle all outputs 0, IDLE; a following start sends config again.
- With IFFT_FRAME_CTRL_CFG_CACHE_EN, two identical starts: config sent only once. Changing cp_len forces a resend.

Source files
------------

// File: rtl/ifft_frame_ctrl.sv
// Sequencer in front of the ifft core: config word, framed data with generated tlast, status.
// Optional: define IFFT_FRAME_CTRL_CFG_CACHE_EN to skip resending a config word the core already holds.
module ifft_frame_ctrl #(
  parameter int DATA_W   = 32,
  parameter int MAX_LOG2 = 6,
  parameter int FRAMES_W = 8
) (
  input  logic                aclk,
  input  logic                rst,
  input  logic                start,
  input  logic [4:0]          nfft_log2,
  input  logic [6:0]          cp_len,
  input  logic                fwd_inv,
  input  logic [FRAMES_W-1:0] frames,
  input  logic [DATA_W-1:0]   s_tdata,
  input  logic                s_tvalid,
  output logic                s_tready,
  output logic [23:0]         cfg_tdata,
  output logic                cfg_tvalid,
  input  logic                cfg_tready,
  output logic [DATA_W-1:0]   dat_tdata,
  output logic                dat_tvalid,
  input  logic                dat_tready,
  output logic                dat_tlast,
  input  logic                ev_tlast_missing,
  input  logic                ev_tlast_unexpected,
  output logic                busy,
  output logic                done,
  output logic                err_cfg,
  output logic                err_tlast,
  output logic [FRAMES_W-1:0] frame_cnt
);

  localparam int CNT_W = MAX_LOG2;
  localparam logic [4:0] MAX_L = 5'(MAX_LOG2);

  typedef enum logic [1:0] {IDLE, CFG, DATA, DONE} state_t;

  state_t                state_q;
  logic [4:0]            nfftLog2_q;
  logic [6:0]            cpLen_q;
  logic                  fwdInv_q;
  logic [FRAMES_W-1:0]   frames_q;
  logic [FRAMES_W-1:0]   frameCnt_q;
  logic [FRAMES_W-1:0]   frameCnt_d;
  logic [CNT_W-1:0]      sampleCnt_q;
  logic [CNT_W-1:0]      lastIdx;
  logic                  errCfg_q;
  logic                  errTlast_q;
  logic                  startOk;
  logic                  skipCfg;
  logic                  inData;
  logic                  beatFire;
  logic                  lastCount;

  assign startOk = (nfft_log2 >= 5'd3) && (nfft_log2 <= MAX_L) && (frames != '0);
  assign lastIdx = CNT_W'((32'd1 << nfftLog2_q) - 32'd1);

`ifdef IFFT_FRAME_CTRL_CFG_CACHE_EN
  logic        cacheValid_q;
  logic [23:0] cacheWord_q;
  logic [23:0] reqWord;

  assign reqWord = {7'b0, fwd_inv, 1'b0, cp_len, 3'b0, nfft_log2};
  assign skipCfg = cacheValid_q && (cacheWord_q == reqWord);
`else
  assign skipCfg = 1'b0;
`endif

  // Valid/ready drop combinationally while reset is asserted, not one cycle later.
  assign inData     = (state_q == DATA) && !rst;
  assign beatFire   = inData && s_tvalid && dat_tready;
  assign lastCount  = (sampleCnt_q == lastIdx);
  assign frameCnt_d = frameCnt_q + 1'b1;

  assign s_tready   = inData && dat_tready;
  assign dat_tvalid = inData && s_tvalid;
  assign dat_tdata  = inData ? s_tdata : '0;
  assign dat_tlast  = inData && lastCount;

  assign cfg_tvalid = (state_q == CFG) && !rst;
  assign cfg_tdata  = {7'b0, fwdInv_q, 1'b0, cpLen_q, 3'b0, nfftLog2_q};

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign err_cfg   = errCfg_q;
  assign err_tlast = errTlast_q;
  assign frame_cnt = frameCnt_q;

  always_ff @(posedge aclk) begin
    if (rst) begin
      state_q     <= IDLE;
      nfftLog2_q  <= '0;
      cpLen_q     <= '0;
      fwdInv_q    <= 1'b0;
      frames_q    <= '0;
      frameCnt_q  <= '0;
      sampleCnt_q <= '0;
      errCfg_q    <= 1'b0;
      errTlast_q  <= 1'b0;
`ifdef IFFT_FRAME_CTRL_CFG_CACHE_EN
      cacheValid_q <= 1'b0;
      cacheWord_q  <= '0;
`endif
    end else begin
      errCfg_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (startOk) begin
              nfftLog2_q  <= nfft_log2;
              cpLen_q     <= cp_len;
              fwdInv_q    <= fwd_inv;
              frames_q    <= frames;
              frameCnt_q  <= '0;
              sampleCnt_q <= '0;
              errTlast_q  <= 1'b0;
              state_q     <= skipCfg ? DATA : CFG;
            end else begin
              errCfg_q <= 1'b1;
            end
          end
        end
        CFG: begin
          if (cfg_tready) begin
            state_q <= DATA;
`ifdef IFFT_FRAME_CTRL_CFG_CACHE_EN
            cacheValid_q <= 1'b1;
            cacheWord_q  <= cfg_tdata;
`endif
          end
        end
        DATA: begin
          if (beatFire) begin
            if (lastCount) begin
              sampleCnt_q <= '0;
              frameCnt_q  <= frameCnt_d;
              if (frameCnt_d == frames_q) state_q <= DONE;
            end else begin
              sampleCnt_q <= sampleCnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
      // Core tlast events win over the clear from an accepted start in the same cycle.
      if (ev_tlast_missing || ev_tlast_unexpected) errTlast_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ifft_frame_ctrl.sv
// Directed bench for ifft_frame_ctrl: scoreboard of expected beats, immediate-assertion checks.
// Cache checks follow IFFT_FRAME_CTRL_CFG_CACHE_EN when the bench is built with it.
module tb_ifft_frame_ctrl;

  localparam int DATA_W   = 32;
  localparam int MAX_LOG2 = 6;
  localparam int FRAMES_W = 8;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [4:0]          nfft_log2 = '0;
  logic [6:0]          cp_len = '0;
  logic                fwd_inv = 1'b0;
  logic [FRAMES_W-1:0] frames = '0;
  logic [DATA_W-1:0]   s_tdata = '0;
  logic                s_tvalid = 1'b0;
  logic                s_tready;
  logic [23:0]         cfg_tdata;
  logic                cfg_tvalid;
  logic                cfg_tready = 1'b1;
  logic [DATA_W-1:0]   dat_tdata;
  logic                dat_tvalid;
  logic                dat_tready = 1'b1;
  logic                dat_tlast;
  logic                ev_tlast_missing = 1'b0;
  logic                ev_tlast_unexpected = 1'b0;
  logic                busy;
  logic                done;
  logic                err_cfg;
  logic                err_tlast;
  logic [FRAMES_W-1:0] frame_cnt;

  ifft_frame_ctrl #(.DATA_W(DATA_W), .MAX_LOG2(MAX_LOG2), .FRAMES_W(FRAMES_W)) dut (
    .aclk(aclk), .rst(rst), .start(start), .nfft_log2(nfft_log2), .cp_len(cp_len),
    .fwd_inv(fwd_inv), .frames(frames), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tready(s_tready), .cfg_tdata(cfg_tdata), .cfg_tvalid(cfg_tvalid),
    .cfg_tready(cfg_tready), .dat_tdata(dat_tdata), .dat_tvalid(dat_tvalid),
    .dat_tready(dat_tready), .dat_tlast(dat_tlast), .ev_tlast_missing(ev_tlast_missing),
    .ev_tlast_unexpected(ev_tlast_unexpected), .busy(busy), .done(done),
    .err_cfg(err_cfg), .err_tlast(err_tlast), .frame_cnt(frame_cnt)
  );

  int          checks = 0;
  int          failures = 0;
  logic [32:0] sbQ[$];
  int          genIdx = 0;
  int          beats = 0;
  int          lastSeen = 0;
  int          cfgCount = 0;
  int          doneCount = 0;
  logic [23:0] lastCfg = '0;
  bit          readyToggle = 1'b0;
  bit          modelCacheValid = 1'b0;
  logic [23:0] modelCacheWord = '0;

  function automatic logic [31:0] pattern(input int k);
    return 32'h1357_0000 + 32'(k) * 32'h0001_0011 + 32'd1;
  endfunction

  function automatic logic [23:0] cfgWord(input logic [4:0] n, input logic [6:0] c, input logic f);
    return {7'b0, f, 1'b0, c, 3'b0, n};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: monitor at the falling edge, then move upstream/ready drives just after the rising edge.
  task automatic stepCycle();
    logic        upHs;
    logic [32:0] e;
    @(negedge aclk);
    if (dat_tvalid && dat_tready) begin
      checkOutput("sb_nonempty", 32'(sbQ.size() != 0), 32'd1);
      if (sbQ.size() != 0) begin
        e = sbQ.pop_front();
        checkOutput("beat_data", dat_tdata, e[31:0]);
        checkOutput("beat_last", 32'(dat_tlast), 32'(e[32]));
      end
      beats++;
      if (dat_tlast) lastSeen++;
    end
    if (cfg_tvalid && cfg_tready) begin
      cfgCount++;
      lastCfg = cfg_tdata;
    end
    if (done) doneCount++;
    upHs = s_tvalid && s_tready;
    @(posedge aclk);
    #1;
    if (upHs) genIdx++;
    s_tdata = pattern(genIdx);
    if (readyToggle) dat_tready = !dat_tready;
  endtask

  task automatic applyStimulus(input logic [4:0] n, input logic [6:0] c, input logic f,
                               input logic [7:0] frm, output int expCfg, output logic [23:0] w);
    bit ok;
    int nPts;
    ok = (n >= 5'd3) && (n <= 5'(MAX_LOG2)) && (frm != 8'd0);
    w = cfgWord(n, c, f);
    nfft_log2 = n;
    cp_len = c;
    fwd_inv = f;
    frames = frm;
    start = 1'b1;
    stepCycle();
    start = 1'b0;
    nfft_log2 = 5'd31;
    cp_len = 7'h7f;
    fwd_inv = !f;
    frames = 8'hff;
    expCfg = 0;
    if (ok) begin
      expCfg = 1;
`ifdef IFFT_FRAME_CTRL_CFG_CACHE_EN
      if (modelCacheValid && modelCacheWord == w) expCfg = 0;
`endif
      if (expCfg == 1) begin
        modelCacheValid = 1'b1;
        modelCacheWord = w;
      end
      nPts = 1 << n;
      for (int k = 0; k < int'(frm) * nPts; k++)
        sbQ.push_back({((k % nPts) == nPts - 1), pattern(genIdx + k)});
    end
  endtask

  task automatic runUntilDone(input string tag, input int budget);
    int d0;
    int n;
    d0 = doneCount;
    n = 0;
    while (doneCount == d0 && n < budget) begin
      stepCycle();
      n++;
    end
    checkOutput({tag, "_done_pulse"}, 32'(doneCount - d0), 32'd1);
  endtask

  task automatic burstSummary(input string tag, input int c0, input int b0, input int l0,
                              input int expCfg, input logic [23:0] expWord, input int expBeats,
                              input int expFrames);
    checkOutput({tag, "_cfg_count"}, 32'(cfgCount - c0), 32'(expCfg));
    checkOutput({tag, "_cfg_word"}, 32'(lastCfg), 32'(expWord));
    checkOutput({tag, "_beats"}, 32'(beats - b0), 32'(expBeats));
    checkOutput({tag, "_tlasts"}, 32'(lastSeen - l0), 32'(expFrames));
    checkOutput({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(expFrames));
    checkOutput({tag, "_busy_after"}, 32'(busy), 32'd0);
    checkOutput({tag, "_sb_empty"}, 32'(sbQ.size()), 32'd0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_err_cfg"}, 32'(err_cfg), 32'd0);
    checkOutput({tag, "_err_tlast"}, 32'(err_tlast), 32'd0);
    checkOutput({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    checkOutput({tag, "_cfg_tvalid"}, 32'(cfg_tvalid), 32'd0);
    checkOutput({tag, "_cfg_tdata"}, 32'(cfg_tdata), 32'd0);
    checkOutput({tag, "_dat_tvalid"}, 32'(dat_tvalid), 32'd0);
    checkOutput({tag, "_dat_tlast"}, 32'(dat_tlast), 32'd0);
    checkOutput({tag, "_dat_tdata"}, dat_tdata, 32'd0);
    checkOutput({tag, "_s_tready"}, 32'(s_tready), 32'd0);
  endtask

  initial begin
    int          c0, b0, l0, expCfg, n;
    logic [23:0] w;

    s_tvalid = 1'b1;
    s_tdata = pattern(0);
    rst = 1'b1;
    repeat (3) stepCycle();
    rst = 1'b0;
    checkAllZero("reset");

    $display("[TB] single 8-point frame");
    c0 = cfgCount; b0 = beats; l0 = lastSeen;
    applyStimulus(5'd3, 7'd64, 1'b0, 8'd1, expCfg, w);
    checkOutput("t1_cfg_tvalid", 32'(cfg_tvalid), 32'd1);
    checkOutput("t1_cfg_const", 32'(cfg_tdata), 32'h004003);
    runUntilDone("t1", 100);
    burstSummary("t1", c0, b0, l0, expCfg, w, 8, 1);

    $display("[TB] three 16-point frames, toggling core ready");
    readyToggle = 1'b1;
    c0 = cfgCount; b0 = beats; l0 = lastSeen;
    applyStimulus(5'd4, 7'd5, 1'b1, 8'd3, expCfg, w);
    runUntilDone("t2", 400);
    readyToggle = 1'b0;
    dat_tready = 1'b1;
    burstSummary("t2", c0, b0, l0, expCfg, w, 48, 3);

    $display("[TB] config stall");
    cfg_tready = 1'b0;
    c0 = cfgCount; b0 = beats; l0 = lastSeen;
    applyStimulus(5'd5, 7'd10, 1'b1, 8'd1, expCfg, w);
    for (int i = 0; i < 5; i++) begin
      checkOutput("t3_stall_tvalid", 32'(cfg_tvalid), 32'd1);
      checkOutput("t3_stall_tdata", 32'(cfg_tdata), 32'(w));
      checkOutput("t3_stall_no_data", 32'(beats - b0), 32'd0);
      stepCycle();
    end
    checkOutput("t3_stall_no_cfg_hs", 32'(cfgCount - c0), 32'd0);
    cfg_tready = 1'b1;
    runUntilDone("t3", 200);
    burstSummary("t3", c0, b0, l0, expCfg, w, 32, 1);

    $display("[TB] rejected starts");
    c0 = cfgCount;
    applyStimulus(5'd7, 7'd0, 1'b0, 8'd1, expCfg, w);
    checkOutput("t4a_err_cfg", 32'(err_cfg), 32'd1);
    checkOutput("t4a_busy", 32'(busy), 32'd0);
    checkOutput("t4a_cfg_tvalid", 32'(cfg_tvalid), 32'd0);
    stepCycle();
    checkOutput("t4a_err_cfg_pulse", 32'(err_cfg), 32'd0);
    applyStimulus(5'd3, 7'd0, 1'b0, 8'd0, expCfg, w);
    checkOutput("t4b_err_cfg", 32'(err_cfg), 32'd1);
    checkOutput("t4b_busy", 32'(busy), 32'd0);
    stepCycle();
    checkOutput("t4b_err_cfg_pulse", 32'(err_cfg), 32'd0);
    checkOutput("t4_no_cfg", 32'(cfgCount - c0), 32'd0);

    $display("[TB] tlast event during data");
    c0 = cfgCount; b0 = beats; l0 = lastSeen;
    applyStimulus(5'd3, 7'd1, 1'b0, 8'd2, expCfg, w);
    repeat (3) stepCycle();
    ev_tlast_unexpected = 1'b1;
    stepCycle();
    ev_tlast_unexpected = 1'b0;
    checkOutput("t5_err_tlast_set", 32'(err_tlast), 32'd1);
    runUntilDone("t5", 100);
    checkOutput("t5_err_tlast_sticky", 32'(err_tlast), 32'd1);
    burstSummary("t5", c0, b0, l0, expCfg, w, 16, 2);

    $display("[TB] reset mid-frame");
    b0 = beats;
    applyStimulus(5'd3, 7'd2, 1'b1, 8'd1, expCfg, w);
    checkOutput("t6_err_tlast_cleared", 32'(err_tlast), 32'd0);
    n = 0;
    while ((beats - b0) < 4 && n < 50) begin
      stepCycle();
      n++;
    end
    checkOutput("t6_reached_beat4", 32'(beats - b0), 32'd4);
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    checkAllZero("t6_rst");
    sbQ.delete();
    modelCacheValid = 1'b0;
    c0 = cfgCount; b0 = beats; l0 = lastSeen;
    applyStimulus(5'd3, 7'd2, 1'b1, 8'd1, expCfg, w);
    checkOutput("t6_cfg_again", 32'(cfg_tvalid), 32'd1);
    runUntilDone("t6", 100);
    burstSummary("t6", c0, b0, l0, expCfg, w, 8, 1);

    $display("[TB] repeated and changed config");
    for (int r = 0; r < 3; r++) begin
      c0 = cfgCount; b0 = beats; l0 = lastSeen;
      applyStimulus(5'd4, (r == 2) ? 7'd21 : 7'd20, 1'b1, 8'd1, expCfg, w);
      runUntilDone("t7", 200);
      burstSummary("t7", c0, b0, l0, expCfg, w, 16, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
